// File: rtl/regfile.sv
// 32-entry register file: two combinational read ports, one clocked write port, r0 reads zero.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write onto a matching read port.
module regfile #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we3,
  input  logic [ADDR_BITS-1:0] ra1,
  input  logic [ADDR_BITS-1:0] ra2,
  input  logic [ADDR_BITS-1:0] wa3,
  input  logic [WIDTH-1:0]     wd3,
  output logic [WIDTH-1:0]     rd1,
  output logic [WIDTH-1:0]     rd2
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Entry 0 has no storage; the read muxes return zero for it.
  logic [WIDTH-1:0] mem [1:DEPTH-1];
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (we3 && (wa3 == ADDR_BITS'(i))) mem[i] <= wd3;
      end
    end
  end

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ra1 == ADDR_BITS'(i)) stored1 = mem[i];
      if (ra2 == ADDR_BITS'(i)) stored2 = mem[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_live;

  // Forward only a write that will actually land; held reset masks it.
  assign wr_live = reset_n && we3 && (wa3 != '0);
  assign rd1     = (wr_live && (wa3 == ra1)) ? wd3 : stored1;
  assign rd2     = (wr_live && (wa3 == ra2)) ? wd3 : stored2;
`else
  assign rd1 = stored1;
  assign rd2 = stored2;
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic against an array model.
module tb_regfile;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 5;
  localparam int DEPTH     = 32;

  logic                 clk;
  logic                 reset_n;
  logic                 we3;
  logic [ADDR_BITS-1:0] ra1;
  logic [ADDR_BITS-1:0] ra2;
  logic [ADDR_BITS-1:0] wa3;
  logic [WIDTH-1:0]     wd3;
  logic [WIDTH-1:0]     rd1;
  logic [WIDTH-1:0]     rd2;

  int total;
  int bad;

  logic [WIDTH-1:0] model [DEPTH];

  regfile #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .we3(we3), .ra1(ra1), .ra2(ra2),
    .wa3(wa3), .wd3(wd3), .rd1(rd1), .rd2(rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endfunction

  // Expected read value given the current (pre-edge) inputs.
  function automatic logic [WIDTH-1:0] expect_rd(input logic [ADDR_BITS-1:0] a);
    if (!reset_n || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 != 0 && wa3 == a) return wd3;
`endif
    return model[a];
  endfunction

  // Advance one rising edge, mirror the architectural write, settle 1ns later.
  task automatic tick();
    logic                 w;
    logic [ADDR_BITS-1:0] a;
    logic [WIDTH-1:0]     d;
    w = we3; a = wa3; d = wd3;
    @(posedge clk);
    if (reset_n && w && a != 0) model[a] = d;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0;
    ra1 = 5'd5; ra2 = 5'd31;
    model_clear();
    #1;
    total++; if (rd1 !== '0) begin bad++; $display("FAIL reset_rd1 got=%h want=0", rd1); end
    total++; if (rd2 !== '0) begin bad++; $display("FAIL reset_rd2 got=%h want=0", rd2); end
    // A write attempted under reset must not land.
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hABCD0123;
    tick();
    we3 = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (rd1 !== '0) begin bad++; $display("FAIL post_reset_rd1 cyc=%0d got=%h want=0", c, rd1); end
      total++; if (rd2 !== '0) begin bad++; $display("FAIL post_reset_rd2 cyc=%0d got=%h want=0", c, rd2); end
    end
  endtask

  task automatic test_basic();
    we3 = 1'b1; wa3 = 5'd8; wd3 = 32'hDEADBEEF;
    tick();
    we3 = 1'b0; ra1 = 5'd8; ra2 = 5'd9;
    #1;
    total++; if (rd1 !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd1 got=%h want=deadbeef", rd1); end
    total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL basic_rd2 got=%h want=0", rd2); end
  endtask

  task automatic test_r0();
    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFFFFFF;
    ra1 = 5'd0; ra2 = 5'd0;
    #1;
    total++; if (rd1 !== '0) begin bad++; $display("FAIL r0_same_cycle got=%h want=0", rd1); end
    tick();
    we3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (rd1 !== '0) begin bad++; $display("FAIL r0_rd1 cyc=%0d got=%h want=0", c, rd1); end
      total++; if (rd2 !== '0) begin bad++; $display("FAIL r0_rd2 cyc=%0d got=%h want=0", c, rd2); end
      tick();
    end
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] want_pre;
    we3 = 1'b1; wa3 = 5'd8; wd3 = 32'h11111111;
    tick();
    ra1 = 5'd8; we3 = 1'b1; wa3 = 5'd8; wd3 = 32'h22222222;
    #1;
`ifdef REGFILE_BYPASS_EN
    want_pre = 32'h22222222;
`else
    want_pre = 32'h11111111;
`endif
    total++; if (rd1 !== want_pre) begin bad++; $display("FAIL collision_pre got=%h want=%h", rd1, want_pre); end
    tick();
    we3 = 1'b0;
    #1;
    total++; if (rd1 !== 32'h22222222) begin bad++; $display("FAIL collision_post got=%h want=22222222", rd1); end
  endtask

  task automatic test_async_reset();
    we3 = 1'b1; wa3 = 5'd31; wd3 = 32'h00400020;
    tick();
    we3 = 1'b0; ra1 = 5'd31; ra2 = 5'd4;
    #1;
    total++; if (rd1 !== 32'h00400020) begin bad++; $display("FAIL r31_write got=%h want=00400020", rd1); end
    // Now 2ns past the edge; pulse reset for 3ns, well before the next edge.
    reset_n = 1'b0; we3 = 1'b1; wa3 = 5'd4; wd3 = 32'd7;
    model_clear();
    #1;
    total++; if (rd1 !== '0) begin bad++; $display("FAIL async_rd1 got=%h want=0", rd1); end
    total++; if (rd2 !== '0) begin bad++; $display("FAIL async_rd2 got=%h want=0", rd2); end
    #2;
    reset_n = 1'b1; we3 = 1'b0;
    tick();
    total++; if (rd2 !== '0) begin bad++; $display("FAIL async_r4 got=%h want=0", rd2); end
    total++; if (rd1 !== '0) begin bad++; $display("FAIL async_r31 got=%h want=0", rd1); end
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] want;
    for (int i = 1; i < DEPTH; i++) begin
      we3 = 1'b1; wa3 = ADDR_BITS'(i); wd3 = WIDTH'(i) * 32'h01010101;
      tick();
    end
    we3 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = ADDR_BITS'(i); ra2 = ADDR_BITS'(i);
      want = WIDTH'(i) * 32'h01010101;
      #1;
      total++; if (rd1 !== want) begin bad++; $display("FAIL sweep_rd1 r%0d got=%h want=%h", i, rd1, want); end
      total++; if (rd2 !== want) begin bad++; $display("FAIL sweep_rd2 r%0d got=%h want=%h", i, rd2, want); end
      total++; if (rd1 !== rd2) begin bad++; $display("FAIL sweep_same r%0d rd1=%h rd2=%h", i, rd1, rd2); end
      ra2 = ADDR_BITS'(DEPTH - 1 - i);
      want = WIDTH'(DEPTH - 1 - i) * 32'h01010101;
      #1;
      total++; if (rd2 !== want) begin bad++; $display("FAIL sweep_cross r%0d got=%h want=%h", DEPTH - 1 - i, rd2, want); end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    for (int c = 0; c < 300; c++) begin
      we3 = 1'($urandom_range(0, 1));
      wa3 = ADDR_BITS'($urandom_range(0, DEPTH - 1));
      wd3 = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa3 : ADDR_BITS'($urandom_range(0, DEPTH - 1));
      ra2 = ADDR_BITS'($urandom_range(0, DEPTH - 1));
      #1;
      e1 = expect_rd(ra1);
      e2 = expect_rd(ra2);
      total++; if (rd1 !== e1) begin bad++; $display("FAIL rand_rd1 cyc=%0d ra1=%0d got=%h want=%h", c, ra1, rd1, e1); end
      total++; if (rd2 !== e2) begin bad++; $display("FAIL rand_rd2 cyc=%0d ra2=%0d got=%h want=%h", c, ra2, rd2, e2); end
      tick();
    end
    we3 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_r0();
    test_collision();
    test_async_reset();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
